// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard scheduler: forwarding encodings and the
// shadow stage record. Pure declarations, no logic, so no latency applies.
// No flow control: values only.
package hazard_pkg;

    // Register-address width carried inside each stage record.
    localparam int REC_AW = 5;

    // EX operand source selects.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // What the scheduler remembers about the instruction occupying a stage.
    typedef struct packed {
        logic              valid;
        logic [REC_AW-1:0] rd;
        logic              we;
        logic              is_load;
        logic [REC_AW-1:0] rs1;
        logic [REC_AW-1:0] rs2;
        logic              uses1;
        logic              uses2;
    } stage_rec_t;

    // A stage produces a value worth forwarding or waiting on only when it
    // really writes the regfile and the target is not the hardwired x0.
    function automatic logic is_writer(stage_rec_t r);
        return r.valid & r.we & (r.rd != '0);
    endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// Single shadow stage record register with hold / clear / load controls.
// Latency: one cycle from d to q.
// Backpressure: hold wins over clear and load; clear inserts an invalid record.
//
// Ports: clock, reset (sync, active-high), load, hold, clear, d (next record),
//        q (current record).
module hazard_stage_rec
    import hazard_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       hold,
    input  logic       clear,
    input  stage_rec_t d,
    output stage_rec_t q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (hold) begin
            q <= q;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline scheduler: stall/bubble/flush/freeze and EX forwarding.
// Latency: controls are combinational (same cycle); records/counters registered.
// Backpressure: mem_busy freezes the whole pipe and holds all internal state.
//
// Ports:
//   clock, reset            core clock, synchronous active-high reset
//   id_*                    decoded fields of the instruction sitting in ID
//   ex_redirect             EX resolved a taken branch or jump
//   mem_busy                data memory not ready
//   stall_f/stall_d         hold PC / IF-ID
//   bubble_e                load NOP into ID/EX
//   flush_d/flush_e         clear IF-ID / ID-EX
//   freeze                  hold ID/EX, EX/MEM, MEM/WB
//   fwd_a/fwd_b             EX operand sources (FWD_RF/FWD_MEM/FWD_WB)
//   stall_count/flush_count load-use stall cycles / redirects taken
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = REC_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_write_back,
    input  logic              id_is_load,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic              stall_f,
    output logic              stall_d,
    output logic              bubble_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    stage_rec_t id_rec;
    stage_rec_t ex_rec;
    stage_rec_t mem_rec;
    stage_rec_t wb_rec;

    logic redirect;
    logic load_use;
    logic src_hit;

    // Source/destination fields of mem/wb records are kept for symmetry but
    // only rd/we/valid of the older stages feed decisions.
    logic unused_rec_bits;
    assign unused_rec_bits = ^{mem_rec, wb_rec};

    always_comb begin
        id_rec         = '0;
        id_rec.valid   = id_valid;
        id_rec.rd      = id_rd;
        id_rec.we      = id_write_back;
        id_rec.is_load = id_is_load;
        id_rec.rs1     = id_rs1;
        id_rec.rs2     = id_rs2;
        id_rec.uses1   = id_uses_rs1;
        id_rec.uses2   = id_uses_rs2;
    end

    // A redirect seen while frozen stays latched in EX upstream, so it is
    // simply acted on once the freeze drops.
    assign redirect = ex_redirect & ~mem_busy;

    assign src_hit  = (id_uses_rs1 & (id_rs1 == ex_rec.rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rec.rd));

    // The ID instruction is wrong-path under a redirect, so its load-use
    // dependency is irrelevant.
    assign load_use = ~mem_busy & ~ex_redirect & id_valid &
                      is_writer(ex_rec) & ex_rec.is_load & src_hit;

    assign freeze   = mem_busy;
    assign stall_f  = mem_busy | load_use;
    assign stall_d  = mem_busy | load_use;
    assign bubble_e = load_use;
    assign flush_d  = redirect;
    assign flush_e  = redirect;

    // Youngest producer (MEM) takes precedence over WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ex_rec.valid) begin
            if (ex_rec.uses1 && is_writer(mem_rec) && (mem_rec.rd == ex_rec.rs1)) begin
                fwd_a = FWD_MEM;
            end else if (ex_rec.uses1 && is_writer(wb_rec) && (wb_rec.rd == ex_rec.rs1)) begin
                fwd_a = FWD_WB;
            end
            if (ex_rec.uses2 && is_writer(mem_rec) && (mem_rec.rd == ex_rec.rs2)) begin
                fwd_b = FWD_MEM;
            end else if (ex_rec.uses2 && is_writer(wb_rec) && (wb_rec.rd == ex_rec.rs2)) begin
                fwd_b = FWD_WB;
            end
        end
    end

    // EX gets a bubble on redirect or load-use; older stages always advance
    // unless frozen.
    hazard_stage_rec u_ex_rec (
        .clock (clock),
        .reset (reset),
        .load  (1'b1),
        .hold  (mem_busy),
        .clear (redirect | load_use),
        .d     (id_rec),
        .q     (ex_rec)
    );

    hazard_stage_rec u_mem_rec (
        .clock (clock),
        .reset (reset),
        .load  (1'b1),
        .hold  (mem_busy),
        .clear (1'b0),
        .d     (ex_rec),
        .q     (mem_rec)
    );

    hazard_stage_rec u_wb_rec (
        .clock (clock),
        .reset (reset),
        .load  (1'b1),
        .hold  (mem_busy),
        .clear (1'b0),
        .d     (mem_rec),
        .q     (wb_rec)
    );

    // Performance counters wrap silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (load_use) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (redirect) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed pipeline scenarios then random traffic
// compared every cycle against a queue-style pipeline model.
// Inputs driven on the falling edge; outputs sampled 1 time unit later.
module tb_hazard_unit;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_write_back;
    logic        id_is_load;
    logic        ex_redirect;
    logic        mem_busy;
    logic        stall_f;
    logic        stall_d;
    logic        bubble_e;
    logic        flush_d;
    logic        flush_e;
    logic        freeze;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .id_rd         (id_rd),
        .id_write_back (id_write_back),
        .id_is_load    (id_is_load),
        .ex_redirect   (ex_redirect),
        .mem_busy      (mem_busy),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .bubble_e      (bubble_e),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .freeze        (freeze),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
    } ins_t;

    ins_t        pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    int unsigned m_stalls;
    int unsigned m_flushes;
    bit          rst_req;

    function automatic ins_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit we, bit ld);
        ins_t i;
        i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
        i.rd = rd; i.we = we; i.ld = ld;
        return i;
    endfunction

    function automatic ins_t nop_i();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic bit writes(ins_t i);
        return i.v && i.we && (i.rd != 0);
    endfunction

    // Search older stages from youngest to oldest; index doubles as encoding.
    function automatic int exp_fwd(int src, bit uses);
        if (!pipe[0].v || !uses) return 0;
        for (int k = 1; k < 3; k++) begin
            if (writes(pipe[k]) && pipe[k].rd == src) return k;
        end
        return 0;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = nop_i();
        m_stalls  = 0;
        m_flushes = 0;
    endfunction

    // One clock: drive, compare every output against the model, advance model.
    task automatic cyc(input ins_t id, input bit redir, input bit busy);
        bit lu;
        @(negedge clock);
        reset         = rst_req;
        id_valid      = id.v;
        id_rs1        = 5'(id.rs1);
        id_rs2        = 5'(id.rs2);
        id_uses_rs1   = id.u1;
        id_uses_rs2   = id.u2;
        id_rd         = 5'(id.rd);
        id_write_back = id.we;
        id_is_load    = id.ld;
        ex_redirect   = redir;
        mem_busy      = busy;
        #1;
        lu = !busy && !redir && id.v && writes(pipe[0]) && pipe[0].ld &&
             ((id.u1 && id.rs1 == pipe[0].rd) || (id.u2 && id.rs2 == pipe[0].rd));
        check("freeze",      freeze,      busy);
        check("stall_f",     stall_f,     busy || lu);
        check("stall_d",     stall_d,     busy || lu);
        check("bubble_e",    bubble_e,    lu);
        check("flush_d",     flush_d,     redir && !busy);
        check("flush_e",     flush_e,     redir && !busy);
        check("fwd_a",       fwd_a,       exp_fwd(pipe[0].rs1, pipe[0].u1));
        check("fwd_b",       fwd_b,       exp_fwd(pipe[0].rs2, pipe[0].u2));
        check("stall_count", stall_count, m_stalls);
        check("flush_count", flush_count, m_flushes);
        if (rst_req) begin
            model_clear();
        end else if (!busy) begin
            if (redir) m_flushes++;
            else if (lu) m_stalls++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (redir || lu) ? nop_i() : id;
        end
    endtask

    task automatic do_reset();
        rst_req = 1;
        cyc(nop_i(), 0, 0);
        rst_req = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(nop_i(), 0, 0);
    endtask

    initial begin
        rst_req       = 0;
        reset         = 1;
        id_valid      = 0;
        id_rs1        = '0;
        id_rs2        = '0;
        id_uses_rs1   = 0;
        id_uses_rs2   = 0;
        id_rd         = '0;
        id_write_back = 0;
        id_is_load    = 0;
        ex_redirect   = 0;
        mem_busy      = 0;
        repeat (2) @(posedge clock);
        model_clear();

        // Reset state
        cyc(nop_i(), 0, 0);
        check("rst stall_f", stall_f, 0);
        check("rst fwd_a", fwd_a, 0);
        check("rst counts", stall_count | flush_count, 0);

        // add x5,x1,x2 ; sub x6,x5,x3
        do_reset();
        cyc(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0);
        cyc(mk(1, 5, 3, 1, 1, 6, 1, 0), 0, 0);
        cyc(nop_i(), 0, 0);
        check("ex_mem fwd_a", fwd_a, 1);
        check("ex_mem fwd_b", fwd_b, 0);
        check("ex_mem stall", stall_f, 0);

        // add x5 ; nop ; or x7,x0,x5
        do_reset();
        cyc(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0);
        cyc(nop_i(), 0, 0);
        cyc(mk(1, 0, 5, 1, 1, 7, 1, 0), 0, 0);
        cyc(nop_i(), 0, 0);
        check("wb fwd_b", fwd_b, 2);
        check("wb fwd_a", fwd_a, 0);

        // lw x8,0(x1) ; add x9,x8,x8
        do_reset();
        cyc(mk(1, 1, 0, 1, 0, 8, 1, 1), 0, 0);
        cyc(mk(1, 8, 8, 1, 1, 9, 1, 0), 0, 0);
        check("lu stall_f", stall_f, 1);
        check("lu stall_d", stall_d, 1);
        check("lu bubble_e", bubble_e, 1);
        cyc(mk(1, 8, 8, 1, 1, 9, 1, 0), 0, 0);
        check("lu one cycle", stall_f, 0);
        check("lu stall_count", stall_count, 1);
        cyc(nop_i(), 0, 0);
        check("lu fwd_a", fwd_a, 2);
        check("lu fwd_b", fwd_b, 2);

        // beq taken in EX while ID holds lw x8
        do_reset();
        cyc(mk(1, 1, 2, 1, 1, 0, 0, 0), 0, 0);
        cyc(mk(1, 1, 0, 1, 0, 8, 1, 1), 1, 0);
        check("br flush_d", flush_d, 1);
        check("br flush_e", flush_e, 1);
        check("br stall_f", stall_f, 0);
        cyc(nop_i(), 0, 0);
        check("br flush_count", flush_count, 1);
        check("br fwd_a", fwd_a, 0);
        check("br fwd_b", fwd_b, 0);

        // redirect suppresses a concurrent load-use
        do_reset();
        cyc(mk(1, 1, 0, 1, 0, 8, 1, 1), 0, 0);
        cyc(mk(1, 8, 8, 1, 1, 9, 1, 0), 1, 0);
        check("sup bubble_e", bubble_e, 0);
        check("sup flush_d", flush_d, 1);
        cyc(nop_i(), 0, 0);
        check("sup stall_count", stall_count, 0);

        // mem_busy for 3 cycles with a pending redirect
        do_reset();
        cyc(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(nop_i(), 1, 1);
            check("frz freeze", freeze, 1);
            check("frz flush_d", flush_d, 0);
        end
        cyc(nop_i(), 1, 0);
        check("frz late flush", flush_d, 1);
        check("frz released", freeze, 0);
        cyc(nop_i(), 0, 0);
        check("frz flush_count", flush_count, 1);

        // addi x0,x0,5 ; add x1,x0,x0
        do_reset();
        cyc(mk(1, 0, 0, 1, 0, 0, 1, 0), 0, 0);
        cyc(mk(1, 0, 0, 1, 1, 1, 1, 0), 0, 0);
        cyc(nop_i(), 0, 0);
        check("x0 fwd_a", fwd_a, 0);
        check("x0 fwd_b", fwd_b, 0);

        // reset during a load-use stall
        do_reset();
        cyc(mk(1, 1, 0, 1, 0, 8, 1, 1), 0, 0);
        rst_req = 1;
        cyc(mk(1, 8, 8, 1, 1, 9, 1, 0), 0, 0);
        check("rst mid stall", stall_f, 1);
        rst_req = 0;
        cyc(nop_i(), 0, 0);
        check("post rst outs", {stall_f, stall_d, bubble_e, flush_d, flush_e, freeze, fwd_a, fwd_b}, 0);
        check("post rst stall_count", stall_count, 0);
        check("post rst flush_count", flush_count, 0);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            ins_t r;
            bit   we;
            we = ($urandom_range(0, 3) != 0);
            r = mk($urandom_range(0, 9) < 8,
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7), we, we && ($urandom_range(0, 2) == 0));
            rst_req = ($urandom_range(0, 199) == 0);
            cyc(r, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15);
        end
        rst_req = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
